// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad decoder: key codes, FSM state encoding
// and the 4x4 row/column to key-code map.
package keypad_pkg;

   localparam int KEY_W = 4;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      HELD     = 2'd2
   } kp_state_e;

   // True when exactly one bit of a 4-bit vector is set.
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
   endfunction

   // Index of the set bit of a one-hot vector (0 for anything else).
   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Row/column (both one-hot) to key code.
   function automatic logic [3:0] key_map(input logic [3:0] row, input logic [3:0] col);
      logic [3:0] code;
      case ({onehot_idx(row), onehot_idx(col)})
         4'b00_00: code = KEY_1;
         4'b00_01: code = KEY_2;
         4'b00_10: code = KEY_3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = KEY_4;
         4'b01_01: code = KEY_5;
         4'b01_10: code = KEY_6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = KEY_7;
         4'b10_01: code = KEY_8;
         4'b10_10: code = KEY_9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = KEY_0;
         4'b11_10: code = KEY_HASH;
         4'b11_11: code = KEY_D;
         default:  code = KEY_0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Key-code output channel: valid/ready handshake plus error/overflow pulses.
interface keypad_decoder_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       key_error;
   logic       key_overflow;

   modport master (
      output key_valid, key_code, key_error, key_overflow,
      input  key_ready
   );

   modport slave (
      input  key_valid, key_code, key_error, key_overflow,
      output key_ready
   );
endinterface

// File: rtl/keypad_fifo.sv
// First-word-fall-through FIFO for key codes. A push while full is dropped
// and flagged, unless a pop happens on the same edge, in which case the push
// takes the slot being freed.
module keypad_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [KEY_W-1:0] data_i,
   input  logic             pop_i,
   output logic [KEY_W-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             pop_ok_s;
   logic             push_ok_s;

   assign empty_o    = (count_q == {(AW + 1){1'b0}});
   assign full_o     = (count_q == FULL_CNT);
   assign data_o     = mem_q[rd_ptr_q];
   assign overflow_o = ovf_q;

   // Accept/drop decisions and next pointer/count values.
   always_comb begin
      pop_ok_s  = pop_i && !empty_o;
      push_ok_s = push_i && (!full_o || pop_ok_s);
      ovf_d     = push_i && full_o && !pop_ok_s;
      wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers, count and the registered overflow pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {KEY_W{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW + 1){1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: rtl/keypad_decoder.sv
// Keypad decoder: turns each new debounced press from the poller into one
// 4-bit key code, buffered in a FWFT FIFO behind a valid/ready handshake.
// Optional feature macro: KEYPAD_REPEAT_EN enables auto-repeat while a key
// is held (first repeat after REPEAT_DELAY cycles, then every REPEAT_RATE).
module keypad_decoder
   import keypad_pkg::*;
#(
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] REPEAT_DELAY = 16'd1000,
   parameter logic [15:0] REPEAT_RATE  = 16'd250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        keypad_col_in,
   input  logic [3:0]        keypad_row_in,
   input  logic              key_pressed_in,
   keypad_decoder_if.master  kif
);

   kp_state_e  state_q, state_d;
   logic       error_q, error_d;
   logic       push_s;
   logic [3:0] push_code_s;
   logic       pattern_ok_s;
   logic       fifo_empty_s;
   logic       fifo_full_s;
   logic       fifo_ovf_s;

`ifdef KEYPAD_REPEAT_EN
   logic [15:0] rpt_cnt_q, rpt_cnt_d;
   logic        first_q, first_d;
   logic [3:0]  held_code_q, held_code_d;
   logic [15:0] rpt_limit_s;

   assign rpt_limit_s = first_q ? REPEAT_DELAY : REPEAT_RATE;
`else
   logic unused_params_s;
   assign unused_params_s = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

   assign pattern_ok_s = is_onehot4(keypad_row_in) && is_onehot4(keypad_col_in);

   // Next-state, push and error decisions of the press-tracking FSM.
   always_comb begin
      state_d     = state_q;
      push_s      = 1'b0;
      push_code_s = key_map(keypad_row_in, keypad_col_in);
      error_d     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d   = rpt_cnt_q;
      first_d     = first_q;
      held_code_d = held_code_q;
`endif
      case (state_q)
         WAIT_REL: begin
            if (!key_pressed_in) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_REL;
            end
         end
         IDLE: begin
            if (key_pressed_in) begin
               if (pattern_ok_s) begin
                  push_s  = 1'b1;
                  state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                  rpt_cnt_d   = 16'd0;
                  first_d     = 1'b1;
                  held_code_d = key_map(keypad_row_in, keypad_col_in);
`endif
               end else begin
                  error_d = 1'b1;
                  state_d = WAIT_REL;
               end
            end else begin
               state_d = IDLE;
            end
         end
         HELD: begin
            if (!key_pressed_in) begin
               state_d = IDLE;
`ifdef KEYPAD_REPEAT_EN
               rpt_cnt_d = 16'd0;
`endif
            end else begin
               state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
               // Counter runs 0..limit-1 so the push lands exactly limit edges
               // after the previous one.
               if (rpt_cnt_q == (rpt_limit_s - 16'd1)) begin
                  push_s      = 1'b1;
                  push_code_s = held_code_q;
                  rpt_cnt_d   = 16'd0;
                  first_d     = 1'b0;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 16'd1;
               end
`endif
            end
         end
         default: begin
            state_d = WAIT_REL;
         end
      endcase
   end

   // FSM state and error-pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_REL;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         error_q <= error_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   // Auto-repeat counter and the code captured at the start of the press.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_cnt_q   <= 16'd0;
         first_q     <= 1'b1;
         held_code_q <= 4'h0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         first_q     <= first_d;
         held_code_q <= held_code_d;
      end
   end
`endif

   keypad_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push_s),
      .data_i     (push_code_s),
      .pop_i      (kif.key_ready),
      .data_o     (kif.key_code),
      .empty_o    (fifo_empty_s),
      .full_o     (fifo_full_s),
      .overflow_o (fifo_ovf_s)
   );

   assign kif.key_valid    = !fifo_empty_s;
   assign kif.key_error    = error_q;
   assign kif.key_overflow = fifo_ovf_s;

   logic unused_full_s;
   assign unused_full_s = fifo_full_s;

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: directed presses push expected codes into a
// scoreboard queue; a monitor pops and compares on every accepted handshake.
module tb_keypad_decoder;

   logic       clk;
   logic       rst;
   logic [3:0] col;
   logic [3:0] row;
   logic       pressed;

   int total;
   int bad;
   logic [3:0] exp_q[$];

   keypad_decoder_if kif ();

   keypad_decoder #(
      .FIFO_DEPTH   (4),
      .REPEAT_DELAY (16'd10),
      .REPEAT_RATE  (16'd4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .keypad_col_in  (col),
      .keypad_row_in  (row),
      .key_pressed_in (pressed),
      .kif            (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compare the head on every accepted handshake.
   always @(negedge clk) begin
      if (!rst && kif.key_valid && kif.key_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected got=%h exp=none", kif.key_code);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (kif.key_code !== e) begin
               bad++;
               $display("FAIL pop_code got=%h exp=%h", kif.key_code, e);
            end
         end
      end
   end

   task automatic press(input logic [3:0] c, input logic [3:0] r, input int hold);
      col = c;
      row = r;
      pressed = 1'b1;
      step();
      for (int i = 1; i < hold; i++) step();
      pressed = 1'b0;
      step();
      step();
   endtask

   task automatic drain(input string name);
      kif.key_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!kif.key_valid) break;
      end
      kif.key_ready = 1'b0;
      chk({name, "_valid_low"}, {7'd0, kif.key_valid}, 8'd0);
      chk({name, "_sb_empty"}, 8'(exp_q.size()), 8'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      kif.key_ready = 1'b0;
      pressed = 1'b1;
      col = 4'b0010;
      row = 4'b0001;
      step(); step(); step();
      chk("rst_valid", {7'd0, kif.key_valid}, 8'd0);
      chk("rst_code", {4'd0, kif.key_code}, 8'h00);
      chk("rst_error", {7'd0, kif.key_error}, 8'd0);
      chk("rst_ovf", {7'd0, kif.key_overflow}, 8'd0);

      // Key held through reset never yields a code.
      rst = 1'b0;
      step(); step(); step();
      chk("held_thru_rst", {7'd0, kif.key_valid}, 8'd0);
      pressed = 1'b0;
      step();
      exp_q.push_back(4'h2);
      pressed = 1'b1;
      step();
      chk("press2_valid", {7'd0, kif.key_valid}, 8'd1);
      chk("press2_code", {4'd0, kif.key_code}, 8'h02);
      pressed = 1'b0;
      step();
      drain("t1");

      // Star then hash buffered, then popped in order.
      exp_q.push_back(4'hE);
      press(4'b0001, 4'b1000, 1);
      exp_q.push_back(4'hF);
      press(4'b0100, 4'b1000, 1);
      chk("two_valid", {7'd0, kif.key_valid}, 8'd1);
      chk("two_head", {4'd0, kif.key_code}, 8'h0E);
      kif.key_ready = 1'b1;
      step();
      chk("two_after_pop1", {7'd0, kif.key_valid}, 8'd1);
      step();
      kif.key_ready = 1'b0;
      chk("two_after_pop2", {7'd0, kif.key_valid}, 8'd0);
      chk("two_sb_empty", 8'(exp_q.size()), 8'd0);

      // Malformed row: error pulse, no push, ignored until release.
      col = 4'b0001;
      row = 4'b0011;
      pressed = 1'b1;
      step();
      chk("err_pulse", {7'd0, kif.key_error}, 8'd1);
      row = 4'b0001;
      step();
      chk("err_one_cycle", {7'd0, kif.key_error}, 8'd0);
      step(); step();
      chk("err_no_push", {7'd0, kif.key_valid}, 8'd0);
      pressed = 1'b0;
      step(); step();
      chk("err_after_rel", {7'd0, kif.key_valid}, 8'd0);

      // Fill FIFO, then overflow on the fifth press.
      exp_q.push_back(4'h1); press(4'b0001, 4'b0001, 1);
      exp_q.push_back(4'h5); press(4'b0010, 4'b0010, 1);
      exp_q.push_back(4'h9); press(4'b0100, 4'b0100, 1);
      exp_q.push_back(4'h0); press(4'b0010, 4'b1000, 1);
      col = 4'b1000;
      row = 4'b1000;
      pressed = 1'b1;
      step();
      chk("ovf_pulse", {7'd0, kif.key_overflow}, 8'd1);
      step();
      chk("ovf_one_cycle", {7'd0, kif.key_overflow}, 8'd0);
      pressed = 1'b0;
      step(); step();
      chk("ovf_head", {4'd0, kif.key_code}, 8'h01);
      // Press while full with a simultaneous pop is accepted.
      exp_q.push_back(4'hA);
      kif.key_ready = 1'b1;
      col = 4'b1000;
      row = 4'b0001;
      pressed = 1'b1;
      step();
      chk("full_pop_no_ovf", {7'd0, kif.key_overflow}, 8'd0);
      pressed = 1'b0;
      step();
      drain("t4");

      // Long hold of key C.
      kif.key_ready = 1'b1;
      exp_q.push_back(4'hC);
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(4'hC);
`endif
      press(4'b1000, 4'b0100, 25);
      drain("t5");

      // Reset with three entries queued and a key held.
      exp_q.push_back(4'h7); press(4'b0001, 4'b0100, 1);
      exp_q.push_back(4'h8); press(4'b0010, 4'b0100, 1);
      col = 4'b0100;
      row = 4'b0001;
      pressed = 1'b1;
      step(); step();
      chk("pre_rst_valid", {7'd0, kif.key_valid}, 8'd1);
      rst = 1'b1;
      step();
      exp_q.delete();
      chk("rst2_valid", {7'd0, kif.key_valid}, 8'd0);
      chk("rst2_code", {4'd0, kif.key_code}, 8'h00);
      rst = 1'b0;
      step(); step(); step();
      chk("rst2_held", {7'd0, kif.key_valid}, 8'd0);
      pressed = 1'b0;
      step();
      exp_q.push_back(4'h6);
      press(4'b0100, 4'b0010, 1);
      chk("rst2_repress", {7'd0, kif.key_valid}, 8'd1);
      drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
